// File: rtl/hazard_pkg.sv
// Shared constants for the RV32I hazard/stall controller.
// Operand-select codes and FSM state encodings.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MD_WAIT  = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One operand's bypass select: M beats W, x0 never forwards,
// and a load still in M cannot feed E (its data is not back yet).
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              wen_rf_m,
    input  logic              wen_rf_w,
    input  logic              is_load_m,
    output logic [1:0]        fw
);

    logic rs_nz;

    assign rs_nz = (rs_e != '0);

    always_comb begin
        fw = FWD_RF;
        if (rs_nz && wen_rf_m && !is_load_m && (rd_m == rs_e))
            fw = FWD_M;
        else if (rs_nz && wen_rf_w && (rd_w == rs_e))
            fw = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/stall controller for the 5-stage RV32I pipeline:
// bypass selects, load-use, redirect, mul/div hold and dmem wait.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              wen_rf_e,
    input  logic              wen_rf_m,
    input  logic              wen_rf_w,
    input  logic              is_load_e,
    input  logic              is_load_m,
    input  logic              md_start_e,
    input  logic              dmem_req_m,
    input  logic              dmem_ack_m,
    input  logic              redirect_e,
    output logic [1:0]        fw_a_e,
    output logic [1:0]        fw_b_e,
    output logic              en_pc_f,
    output logic              en_d,
    output logic              en_e,
    output logic              en_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic              md_busy,
    output logic              md_done
);

    localparam int               CNT_W    = $clog2(MD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               MD_MULTI = (MD_LAT > 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       fw_a_raw;
    logic [1:0]       fw_b_raw;
    logic             load_use;
    logic             lu_stall;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e      (rs1_e),
        .rd_m      (rd_m),
        .rd_w      (rd_w),
        .wen_rf_m  (wen_rf_m),
        .wen_rf_w  (wen_rf_w),
        .is_load_m (is_load_m),
        .fw        (fw_a_raw)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e      (rs2_e),
        .rd_m      (rd_m),
        .rd_w      (rd_w),
        .wen_rf_m  (wen_rf_m),
        .wen_rf_w  (wen_rf_w),
        .is_load_m (is_load_m),
        .fw        (fw_b_raw)
    );

    assign fw_a_e = rst ? FWD_RF : fw_a_raw;
    assign fw_b_e = rst ? FWD_RF : fw_b_raw;

    assign load_use = is_load_e && wen_rf_e && (rd_e != '0) &&
                      ((rs1_d == rd_e) || (rs2_d == rd_e));

    // A redirect squashes the dependent instr in D, so no stall is needed.
    assign lu_stall = load_use && !redirect_e;

    always_comb begin
        state_nxt = ST_RUN;
        cnt_nxt   = cnt;
        en_pc_f   = 1'b1;
        en_d      = 1'b1;
        en_e      = 1'b1;
        en_m      = 1'b1;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        flush_w   = 1'b0;
        md_busy   = 1'b0;
        md_done   = 1'b0;
        unique case (state)
            ST_RUN, ST_MEM_WAIT: begin
                if ((state == ST_MEM_WAIT || dmem_req_m) && !dmem_ack_m) begin
                    en_pc_f   = 1'b0;
                    en_d      = 1'b0;
                    en_e      = 1'b0;
                    en_m      = 1'b0;
                    flush_w   = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                end else if (md_start_e && MD_MULTI) begin
                    en_pc_f   = 1'b0;
                    en_d      = 1'b0;
                    en_e      = 1'b0;
                    flush_m   = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = ST_MD_WAIT;
                end else begin
                    md_done = md_start_e;
                    flush_d = redirect_e;
                    flush_e = redirect_e || lu_stall;
                    en_pc_f = !lu_stall;
                    en_d    = !lu_stall;
                end
            end
            ST_MD_WAIT: begin
                md_busy = 1'b1;
                if (cnt <= CNT_ONE) begin
                    md_done   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_RUN;
                    flush_d   = redirect_e;
                    flush_e   = redirect_e || lu_stall;
                    en_pc_f   = !lu_stall;
                    en_d      = !lu_stall;
                end else begin
                    en_pc_f   = 1'b0;
                    en_d      = 1'b0;
                    en_e      = 1'b0;
                    flush_m   = 1'b1;
                    cnt_nxt   = cnt - CNT_ONE;
                    state_nxt = ST_MD_WAIT;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_RUN;
            end
        endcase
        // Reset holds every stage in bubble until released.
        if (rst) begin
            en_pc_f = 1'b0;
            en_d    = 1'b0;
            en_e    = 1'b0;
            en_m    = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
            md_busy = 1'b0;
            md_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule
